// File: rtl/range_coalescer_pkg.sv
// Shared pair definitions for the range coalescer: the inclusive {lo, hi}
// tuple, the FSM state encoding, the padding sentinel and small pair helpers.
package range_coalescer_pkg;

    localparam int ID_W = 64;

    // Inclusive ID range; lo sits in the upper half so {lo, hi} reads naturally.
    typedef struct packed {
        logic [ID_W-1:0] lo;
        logic [ID_W-1:0] hi;
    } tuple_pair_t;

    localparam int PAIR_W = $bits(tuple_pair_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } range_state_e;

    // Canonical filler element: lo above hi, so it is always skipped.
    localparam tuple_pair_t PAD_PAIR = '{lo: {ID_W{1'b1}}, hi: {ID_W{1'b0}}};

    // Any element whose lo exceeds hi carries no IDs and is ignored.
    function automatic logic pair_is_pad(input tuple_pair_t p);
        return (p.lo > p.hi);
    endfunction

    // Number of IDs in an inclusive range, wrapping at 64 bits.
    function automatic logic [ID_W-1:0] pair_count(input tuple_pair_t p);
        return p.hi - p.lo + 64'd1;
    endfunction

endpackage

// File: rtl/range_accum.sv
// Holds the open range, decides merge versus emit for each element, and
// accumulates the ID count of every emitted range.
module range_accum
    import range_coalescer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear_total,
    input  logic              i_elem_valid,
    input  logic [PAIR_W-1:0] i_elem,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [PAIR_W-1:0] o_range,
    output logic [63:0]       o_total
);

    tuple_pair_t       r_cur;
    logic              r_held;
    logic              r_valid;
    tuple_pair_t       r_range;
    logic [63:0]       r_total;

    tuple_pair_t       w_elem;
    logic              w_take;
    logic              w_touch;
    logic [ID_W-1:0]   w_new_hi;
    tuple_pair_t       w_cur_nxt;
    logic              w_held_nxt;
    logic              w_emit;
    logic [63:0]       w_total_nxt;

    assign w_elem   = i_elem;
    assign w_take   = i_elem_valid & ~pair_is_pad(w_elem);
    // 65-bit compare so an open range ending at all-ones never wraps to 0.
    assign w_touch  = ({1'b0, w_elem.lo} <= ({1'b0, r_cur.hi} + 65'd1));
    assign w_new_hi = (w_elem.hi > r_cur.hi) ? w_elem.hi : r_cur.hi;

    // Merge/emit decision for the element presented this cycle, or the final flush.
    always_comb begin
        w_cur_nxt  = r_cur;
        w_held_nxt = r_held;
        w_emit     = 1'b0;
        if (i_flush) begin
            w_emit     = r_held;
            w_held_nxt = 1'b0;
        end else if (w_take) begin
            if (!r_held) begin
                w_cur_nxt  = w_elem;
                w_held_nxt = 1'b1;
            end else if (w_touch) begin
                w_cur_nxt.hi = w_new_hi;
            end else begin
                w_emit    = 1'b1;
                w_cur_nxt = w_elem;
            end
        end else begin
            w_emit = 1'b0;
        end
    end

    // Running total: cleared at the start of a new job, bumped on each emit.
    always_comb begin
        w_total_nxt = r_total;
        if (i_clear_total) begin
            w_total_nxt = 64'd0;
        end else if (w_emit) begin
            w_total_nxt = r_total + pair_count(r_cur);
        end else begin
            w_total_nxt = r_total;
        end
    end

    // Range state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur   <= '0;
            r_held  <= 1'b0;
            r_valid <= 1'b0;
            r_range <= '0;
            r_total <= 64'd0;
        end else begin
            r_cur   <= w_cur_nxt;
            r_held  <= w_held_nxt;
            r_valid <= w_emit;
            if (w_emit) begin
                r_range <= r_cur;
            end
            r_total <= w_total_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_range = r_range;
    assign o_total = r_total;

endmodule

// File: rtl/range_coalescer.sv
// Accepts sorted blocks of N inclusive ranges, drains them one element per
// cycle into range_accum, and reports coalesced ranges plus the job total.
module range_coalescer
    import range_coalescer_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                last_in,
    input  logic [N*PAIR_W-1:0] pairs_in_flat,
    output logic                ready_out,
    output logic                valid_out,
    output logic [PAIR_W-1:0]   range_out,
    output logic                done_out,
    output logic [63:0]         total_out
);

    localparam int              IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    range_state_e        r_state;
    range_state_e        w_next_state;
    logic [N*PAIR_W-1:0] r_block;
    logic [IDX_W-1:0]    r_idx;
    logic                r_last;
    logic                r_done;

    logic                w_ready;
    logic                w_accept;
    logic                w_elem_valid;
    logic                w_flush;
    logic                w_clear_total;
    logic [PAIR_W-1:0]   w_elem;

    assign w_elem = r_block[int'(r_idx) * PAIR_W +: PAIR_W];

    // Next-state, handshake and datapath controls. The final element of a last
    // block keeps ready low: accepting another block there would fold the next
    // job's ranges into this one before the flush.
    always_comb begin
        w_next_state  = r_state;
        w_ready       = 1'b0;
        w_elem_valid  = 1'b0;
        w_flush       = 1'b0;
        w_clear_total = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready  = 1'b1;
                w_accept = valid_in;
                if (w_accept) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                w_elem_valid = 1'b1;
                w_ready      = (r_idx == LAST_IDX) && !r_last;
                w_accept     = valid_in && w_ready;
                if (r_idx != LAST_IDX) begin
                    w_next_state = DRAIN;
                end else if (w_accept) begin
                    w_next_state = DRAIN;
                end else if (r_last) begin
                    w_next_state = FLUSH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FLUSH: begin
                w_flush      = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                w_ready  = 1'b1;
                w_accept = valid_in;
                if (w_accept) begin
                    w_clear_total = 1'b1;
                    w_next_state  = DRAIN;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, block buffer and element index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_block <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_block <= pairs_in_flat;
                r_last  <= last_in;
                r_idx   <= '0;
            end else if ((r_state == DRAIN) && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end
            r_done <= (w_next_state == DONE);
        end
    end

    range_accum u_accum (
        .clock         (clock),
        .reset         (reset),
        .i_clear_total (w_clear_total),
        .i_elem_valid  (w_elem_valid),
        .i_elem        (w_elem),
        .i_flush       (w_flush),
        .o_valid       (valid_out),
        .o_range       (range_out),
        .o_total       (total_out)
    );

    assign ready_out = w_ready;
    assign done_out  = r_done;

endmodule

// File: tb/tb_range_coalescer.sv
// Directed bench for range_coalescer: table of single-block jobs plus
// hand-written back-to-back and mid-job reset sequences.
module tb_range_coalescer;
    import range_coalescer_pkg::*;

    localparam int N  = 16;
    localparam int NV = 6;

    logic                clock;
    logic                reset;
    logic                valid_in;
    logic                last_in;
    logic [N*PAIR_W-1:0] pairs_in_flat;
    logic                ready_out;
    logic                valid_out;
    logic [PAIR_W-1:0]   range_out;
    logic                done_out;
    logic [63:0]         total_out;

    int n_total = 0;
    int n_bad   = 0;
    logic [PAIR_W-1:0] emits[$];

    typedef struct {
        logic [N*PAIR_W-1:0] pairs;
        int                  n_exp;
        logic [4*PAIR_W-1:0] exp;
        logic [63:0]         exp_total;
    } vec_t;

    vec_t vecs[NV];

    range_coalescer #(.N(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid_in      (valid_in),
        .last_in       (last_in),
        .pairs_in_flat (pairs_in_flat),
        .ready_out     (ready_out),
        .valid_out     (valid_out),
        .range_out     (range_out),
        .done_out      (done_out),
        .total_out     (total_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Collect every emitted range, sampled away from the active edge.
    always @(negedge clock) begin
        if (valid_out === 1'b1) emits.push_back(range_out);
    end

    task automatic chk(input string nm, input logic [PAIR_W-1:0] act, input logic [PAIR_W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [PAIR_W-1:0] mk(input logic [63:0] lo, input logic [63:0] hi);
        return {lo, hi};
    endfunction

    function automatic logic [N*PAIR_W-1:0] all_pads();
        logic [N*PAIR_W-1:0] b;
        for (int k = 0; k < N; k++) b[k*PAIR_W +: PAIR_W] = PAD_PAIR;
        return b;
    endfunction

    task automatic set_elem(input int v, input int k, input logic [63:0] lo, input logic [63:0] hi);
        vecs[v].pairs[k*PAIR_W +: PAIR_W] = mk(lo, hi);
    endtask

    task automatic set_exp(input int v, input int j, input logic [63:0] lo, input logic [63:0] hi);
        vecs[v].exp[j*PAIR_W +: PAIR_W] = mk(lo, hi);
    endtask

    // Present a block once ready is seen; returns at the negedge after accept.
    task automatic send_block(input logic [N*PAIR_W-1:0] p, input logic l);
        int w;
        w = 0;
        while (ready_out !== 1'b1 && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (ready_out !== 1'b1) chk("send_ready_timeout", {127'd0, ready_out}, 128'd1);
        valid_in      = 1'b1;
        pairs_in_flat = p;
        last_in       = l;
        @(negedge clock);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_out !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk("done_out", {127'd0, done_out}, 128'd1);
    endtask

    task automatic chk_emits(input string nm, input int n_exp, input logic [4*PAIR_W-1:0] exp);
        logic [PAIR_W-1:0] e;
        chk({nm, "_count"}, 128'(emits.size()), 128'(n_exp));
        for (int j = 0; j < n_exp; j++) begin
            e = exp[j*PAIR_W +: PAIR_W];
            chk($sformatf("%s_emit%0d", nm, j), (j < emits.size()) ? emits[j] : ~e, e);
        end
    endtask

    initial begin
        logic [N*PAIR_W-1:0] blk_a;
        logic [N*PAIR_W-1:0] blk_b;
        logic [4*PAIR_W-1:0] ex;

        // Vector table: each entry is one last block forming a whole job.
        for (int v = 0; v < NV; v++) begin
            vecs[v].pairs = all_pads();
            vecs[v].exp   = '0;
        end
        set_elem(0, 0, 64'd3, 64'd5);   set_elem(0, 1, 64'd10, 64'd14);
        set_elem(0, 2, 64'd12, 64'd18); set_elem(0, 3, 64'd16, 64'd20);
        set_exp(0, 0, 64'd3, 64'd5);    set_exp(0, 1, 64'd10, 64'd20);
        vecs[0].n_exp = 2; vecs[0].exp_total = 64'd14;

        set_elem(1, 0, 64'd1, 64'd2);   set_elem(1, 1, 64'd3, 64'd4);
        set_elem(1, 2, 64'd20, 64'd30); set_elem(1, 3, 64'd22, 64'd25);
        set_exp(1, 0, 64'd1, 64'd4);    set_exp(1, 1, 64'd20, 64'd30);
        vecs[1].n_exp = 2; vecs[1].exp_total = 64'd15;

        set_elem(2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        set_elem(2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        set_exp(2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[2].n_exp = 1; vecs[2].exp_total = 64'd2;

        vecs[3].n_exp = 0; vecs[3].exp_total = 64'd0;

        set_elem(4, 0, 64'd1, 64'd1);   set_elem(4, 1, 64'd4, 64'd3);
        set_elem(4, 2, 64'd5, 64'd6);   set_elem(4, 3, 64'd7, 64'd7);
        set_exp(4, 0, 64'd1, 64'd1);    set_exp(4, 1, 64'd5, 64'd7);
        vecs[4].n_exp = 2; vecs[4].exp_total = 64'd4;

        set_elem(5, 15, 64'd100, 64'd200);
        set_exp(5, 0, 64'd100, 64'd200);
        vecs[5].n_exp = 1; vecs[5].exp_total = 64'd101;

        valid_in      = 1'b0;
        last_in       = 1'b0;
        pairs_in_flat = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("rst_ready",  {127'd0, ready_out}, 128'd1);
        chk("rst_valid",  {127'd0, valid_out}, 128'd0);
        chk("rst_done",   {127'd0, done_out},  128'd0);
        chk("rst_total",  128'(total_out),     128'd0);
        chk("rst_range",  range_out,           128'd0);

        for (int v = 0; v < NV; v++) begin
            emits.delete();
            send_block(vecs[v].pairs, 1'b1);
            wait_done();
            repeat (2) @(negedge clock);
            chk_emits($sformatf("vec%0d", v), vecs[v].n_exp, vecs[v].exp);
            chk($sformatf("vec%0d_total", v), 128'(total_out), 128'(vecs[v].exp_total));
            chk($sformatf("vec%0d_ready_done", v), {127'd0, ready_out}, 128'd1);
        end

        // Back-to-back blocks with valid held: merge across the boundary.
        emits.delete();
        blk_a = all_pads();
        blk_a[0*PAIR_W +: PAIR_W]  = mk(64'd1, 64'd1);
        blk_a[15*PAIR_W +: PAIR_W] = mk(64'd5, 64'd8);
        blk_b = all_pads();
        blk_b[0*PAIR_W +: PAIR_W]  = mk(64'd7, 64'd12);
        valid_in      = 1'b1;
        pairs_in_flat = blk_a;
        last_in       = 1'b0;
        @(negedge clock);
        chk("b2b_done_clear",  {127'd0, done_out}, 128'd0);
        chk("b2b_total_clear", 128'(total_out),    128'd0);
        pairs_in_flat = blk_b;
        last_in       = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("b2b_ready_a%0d", c), {127'd0, ready_out}, (c == 16) ? 128'd1 : 128'd0);
            if (c < 16) @(negedge clock);
        end
        @(negedge clock);
        valid_in = 1'b0;
        last_in  = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("b2b_ready_b%0d", c), {127'd0, ready_out}, 128'd0);
            @(negedge clock);
        end
        wait_done();
        repeat (2) @(negedge clock);
        ex = '0;
        ex[0*PAIR_W +: PAIR_W] = mk(64'd1, 64'd1);
        ex[1*PAIR_W +: PAIR_W] = mk(64'd5, 64'd12);
        chk_emits("b2b", 2, ex);
        chk("b2b_total", 128'(total_out), 128'd9);

        // Reset while element 7 of a two-block job is being processed.
        blk_a = all_pads();
        for (int k = 0; k < N; k++) blk_a[k*PAIR_W +: PAIR_W] = mk(64'(10 * k), 64'(10 * k + 1));
        send_block(blk_a, 1'b0);
        repeat (7) @(negedge clock);
        #1;
        reset = 1'b1;
        emits.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ready", {127'd0, ready_out}, 128'd1);
        chk("mid_rst_done",  {127'd0, done_out},  128'd0);
        chk("mid_rst_total", 128'(total_out),     128'd0);
        repeat (20) @(negedge clock);
        chk("mid_rst_pulses", 128'(emits.size()), 128'd0);

        emits.delete();
        blk_b = all_pads();
        blk_b[0*PAIR_W +: PAIR_W] = mk(64'd1, 64'd1);
        send_block(blk_b, 1'b1);
        wait_done();
        repeat (2) @(negedge clock);
        ex = '0;
        ex[0*PAIR_W +: PAIR_W] = mk(64'd1, 64'd1);
        chk_emits("post_rst", 1, ex);
        chk("post_rst_total", 128'(total_out), 128'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
